// File: rtl/aes_batch_pkg.sv
// aes_batch_pkg: shared types for the AES batch sequencer.
// Holds the sequencer state encoding and plaintext mode codes.
package aes_batch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_CHAIN = 2'd1;
    localparam logic [1:0] MODE_INCR  = 2'd2;

endpackage

// File: rtl/aes_batch_seq.sv
// aes_batch_seq: runs a programmed number of back-to-back AES encryptions.
// Drives core load, captures ciphertext, and shapes the scope trigger.
module aes_batch_seq
    import aes_batch_pkg::*;
#(
    parameter int pPT_WIDTH    = 128,
    parameter int pCOUNT_WIDTH = 16,
    parameter int pARM_WAIT    = 4
) (
    input  logic                    crypto_clk,
    input  logic                    resetn,
    input  logic                    I_start,
    input  logic                    I_abort,
    input  logic [pCOUNT_WIDTH-1:0] I_count,
    input  logic [1:0]              I_mode,
    input  logic                    I_trig_all,
    input  logic [pPT_WIDTH-1:0]    I_textin,
    output logic [pPT_WIDTH-1:0]    O_textout,
    output logic                    O_load,
    input  logic                    I_core_busy,
    input  logic [pPT_WIDTH-1:0]    I_core_ct,
    output logic [pPT_WIDTH-1:0]    O_cipherout,
    output logic [pCOUNT_WIDTH-1:0] O_iter,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_trigger
);

    localparam int AW = (pARM_WAIT < 2) ? 1 : $clog2(pARM_WAIT);
    localparam logic [AW-1:0] ARM_LAST = AW'(pARM_WAIT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [pPT_WIDTH-1:0]    r_textout;
    logic [pPT_WIDTH-1:0]    r_cipher;
    logic [pCOUNT_WIDTH-1:0] r_count;
    logic [pCOUNT_WIDTH-1:0] r_iter;
    logic [1:0]              r_mode;
    logic                    r_trig_all;
    logic                    r_abort_pend;
    logic [AW-1:0]           r_arm_cnt;
    logic                    r_load;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_trig;

    logic                    w_start_ok;
    logic                    w_abort;
    logic                    w_in_batch;
    logic                    w_core_done;
    logic                    w_last;
    logic                    w_arm_to;
    logic [pCOUNT_WIDTH-1:0] w_iter_inc;
    logic [pPT_WIDTH-1:0]    w_pt_nxt;
    logic                    w_trig_sel;
    logic                    w_active;
    logic                    w_gap;
    logic                    w_load_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_trig_nxt;

    assign w_start_ok  = I_start & ~I_abort;
    assign w_abort     = r_abort_pend | I_abort;
    assign w_in_batch  = (r_state == ST_LOAD) || (r_state == ST_ARM) ||
                         (r_state == ST_RUN);
    assign w_core_done = (r_state == ST_RUN) && !I_core_busy;
    assign w_iter_inc  = r_iter + pCOUNT_WIDTH'(1);
    assign w_last      = (w_iter_inc == r_count);
    assign w_arm_to    = (r_arm_cnt == ARM_LAST);

    // State register
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode; abort only takes effect once the core is idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok)
                    w_state_nxt = (I_count == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: w_state_nxt = ST_ARM;
            ST_ARM: begin
                if (I_core_busy || w_arm_to)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!I_core_busy)
                    w_state_nxt = (w_last || w_abort) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        w_trig_sel = (r_state == ST_IDLE) ? I_trig_all : r_trig_all;
        w_active   = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_ARM) ||
                     (w_state_nxt == ST_RUN);
        w_gap      = w_trig_sel && (r_state == ST_RUN) &&
                     (w_state_nxt == ST_LOAD);
        w_load_nxt = (w_state_nxt == ST_LOAD);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_trig_nxt = w_active && !w_gap;
    end

    // Registered control outputs
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_load <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_trig <= 1'b0;
        end else begin
            r_load <= w_load_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_trig <= w_trig_nxt;
        end
    end

    // Next plaintext selection; reserved mode behaves as fixed
    always_comb begin
        w_pt_nxt = r_textout;
        case (r_mode)
            MODE_CHAIN: w_pt_nxt = I_core_ct;
            MODE_INCR:  w_pt_nxt = r_textout + pPT_WIDTH'(1);
            default:    w_pt_nxt = r_textout;
        endcase
    end

    // Batch parameters latched on start, results captured per encryption
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_textout  <= '0;
            r_cipher   <= '0;
            r_count    <= '0;
            r_iter     <= '0;
            r_mode     <= MODE_FIXED;
            r_trig_all <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_start_ok) begin
            r_textout  <= I_textin;
            r_count    <= I_count;
            r_iter     <= '0;
            r_mode     <= I_mode;
            r_trig_all <= I_trig_all;
        end else if (w_core_done) begin
            r_cipher   <= I_core_ct;
            r_iter     <= w_iter_inc;
            r_textout  <= w_pt_nxt;
        end
    end

    // Sticky abort request, dropped once the batch reaches DONE
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn)                  r_abort_pend <= 1'b0;
        else if (r_state == ST_DONE)  r_abort_pend <= 1'b0;
        else if (I_abort && w_in_batch) r_abort_pend <= 1'b1;
    end

    // Bounded wait for core busy so an instant core cannot stall ARM
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn)                 r_arm_cnt <= '0;
        else if (r_state == ST_ARM)  r_arm_cnt <= r_arm_cnt + AW'(1);
        else                         r_arm_cnt <= '0;
    end

    assign O_textout   = r_textout;
    assign O_cipherout = r_cipher;
    assign O_iter      = r_iter;
    assign O_load      = r_load;
    assign O_busy      = r_busy;
    assign O_done      = r_done;
    assign O_trigger   = r_trig;

endmodule

// File: tb/tb_aes_batch_seq.sv
// tb_aes_batch_seq: directed checks of the AES batch sequencer.
// A stub core returns table-driven ciphertext after a set latency.
module tb_aes_batch_seq;
    import aes_batch_pkg::*;

    localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_CHAIN = 128'hc0ffee000badf00d123456789abcdef0;
    localparam logic [127:0] ONES     = {128{1'b1}};

    logic         crypto_clk;
    logic         resetn;
    logic         I_start;
    logic         I_abort;
    logic [15:0]  I_count;
    logic [1:0]   I_mode;
    logic         I_trig_all;
    logic [127:0] I_textin;
    logic [127:0] O_textout;
    logic         O_load;
    logic         I_core_busy;
    logic [127:0] I_core_ct;
    logic [127:0] O_cipherout;
    logic [15:0]  O_iter;
    logic         O_busy;
    logic         O_done;
    logic         O_trigger;

    int n_checks = 0;
    int n_errors = 0;

    aes_batch_seq u_dut (
        .crypto_clk  (crypto_clk),
        .resetn      (resetn),
        .I_start     (I_start),
        .I_abort     (I_abort),
        .I_count     (I_count),
        .I_mode      (I_mode),
        .I_trig_all  (I_trig_all),
        .I_textin    (I_textin),
        .O_textout   (O_textout),
        .O_load      (O_load),
        .I_core_busy (I_core_busy),
        .I_core_ct   (I_core_ct),
        .O_cipherout (O_cipherout),
        .O_iter      (O_iter),
        .O_busy      (O_busy),
        .O_done      (O_done),
        .O_trigger   (O_trigger)
    );

    initial crypto_clk = 1'b0;
    always #5 crypto_clk = ~crypto_clk;

    // Stub cipher: fixed table for the known vectors, inversion otherwise
    function automatic logic [127:0] stub_enc(input logic [127:0] pt);
        if (pt == PT_FIPS)      return CT_FIPS;
        else if (pt == CT_FIPS) return CT_CHAIN;
        else                    return ~pt;
    endfunction

    // Core model: busy for lat cycles after load, lat 0 finishes instantly
    int         lat = 5;
    logic [3:0] rem;
    always @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            I_core_busy <= 1'b0;
            I_core_ct   <= '0;
            rem         <= '0;
        end else if (O_load) begin
            I_core_ct   <= stub_enc(O_textout);
            I_core_busy <= (lat != 0);
            rem         <= 4'(lat - 1);
        end else if (I_core_busy) begin
            if (rem == 0) I_core_busy <= 1'b0;
            else          rem <= rem - 4'd1;
        end
    end

    // Event monitor: loads (with plaintext), done pulses, trigger rises
    int           n_load = 0;
    int           n_done = 0;
    int           n_trig = 0;
    logic         trig_q = 1'b0;
    logic [127:0] load_pt [16];
    always @(negedge crypto_clk) begin
        if (O_load) begin
            load_pt[n_load[3:0]] <= O_textout;
            n_load <= n_load + 1;
        end
        if (O_done) n_done <= n_done + 1;
        if (O_trigger && !trig_q) n_trig <= n_trig + 1;
        trig_q <= O_trigger;
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_batch(input int cnt, input logic [1:0] mode,
                               input logic trig, input logic [127:0] pt);
        @(negedge crypto_clk);
        I_count    = 16'(cnt);
        I_mode     = mode;
        I_trig_all = trig;
        I_textin   = pt;
        I_start    = 1'b1;
        @(negedge crypto_clk);
        I_start    = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge crypto_clk);
            if (O_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    int   b_load;
    int   b_done;
    int   b_trig;
    logic seen;

    task automatic mark();
        b_load = n_load;
        b_done = n_done;
        b_trig = n_trig;
    endtask

    task automatic settle();
        @(negedge crypto_clk);
        @(negedge crypto_clk);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        I_start    = 1'b0;
        I_abort    = 1'b0;
        I_count    = '0;
        I_mode     = '0;
        I_trig_all = 1'b0;
        I_textin   = '0;
        repeat (3) @(negedge crypto_clk);
        check("rst_ctrl", 128'({O_load, O_busy, O_done, O_trigger}), 0);
        check("rst_iter", 128'(O_iter), 0);
        check("rst_text", O_textout, 0);
        check("rst_ct", O_cipherout, 0);
        resetn = 1'b1;

        // Fixed mode, count 3, per-encryption trigger
        mark();
        start_batch(3, MODE_FIXED, 1'b1, PT_FIPS);
        check("fix_load_t1", 128'(O_load), 1);
        check("fix_busy_t1", 128'(O_busy), 1);
        check("fix_text_t1", O_textout, PT_FIPS);
        wait_done(seen);
        check("fix_done", 128'(seen), 1);
        check("fix_iter", 128'(O_iter), 3);
        check("fix_ct", O_cipherout, CT_FIPS);
        @(negedge crypto_clk);
        check("fix_busy_low", 128'(O_busy), 0);
        settle();
        check("fix_nload", 128'(n_load - b_load), 3);
        check("fix_ndone", 128'(n_done - b_done), 1);
        check("fix_ntrig", 128'(n_trig - b_trig), 3);
        for (int k = 0; k < 3; k++)
            check("fix_pt", load_pt[4'(b_load + k)], PT_FIPS);

        // Chain mode, count 2, batch-wide trigger
        mark();
        start_batch(2, MODE_CHAIN, 1'b0, PT_FIPS);
        wait_done(seen);
        check("chn_done", 128'(seen), 1);
        check("chn_ct", O_cipherout, CT_CHAIN);
        settle();
        check("chn_pt2", load_pt[4'(b_load + 1)], CT_FIPS);
        check("chn_ntrig", 128'(n_trig - b_trig), 1);

        // Increment mode wraps all-ones to zero
        mark();
        start_batch(2, MODE_INCR, 1'b1, ONES);
        wait_done(seen);
        check("inc_done", 128'(seen), 1);
        check("inc_iter", 128'(O_iter), 2);
        check("inc_ct", O_cipherout, ONES);
        settle();
        check("inc_pt1", load_pt[4'(b_load)], ONES);
        check("inc_pt2", load_pt[4'(b_load + 1)], 0);

        // Abort during the second RUN
        lat = 6;
        mark();
        start_batch(5, MODE_FIXED, 1'b1, PT_FIPS);
        for (int i = 0; i < 100; i++) begin
            @(negedge crypto_clk);
            #1;
            if (n_load == b_load + 2) break;
        end
        @(negedge crypto_clk);
        @(negedge crypto_clk);
        I_abort = 1'b1;
        @(negedge crypto_clk);
        I_abort = 1'b0;
        wait_done(seen);
        check("abt_done", 128'(seen), 1);
        check("abt_iter", 128'(O_iter), 2);
        settle();
        check("abt_nload", 128'(n_load - b_load), 2);
        check("abt_ndone", 128'(n_done - b_done), 1);
        lat = 5;

        // Start and abort together: nothing happens
        mark();
        @(negedge crypto_clk);
        I_start = 1'b1;
        I_abort = 1'b1;
        I_count = 16'd3;
        @(negedge crypto_clk);
        I_start = 1'b0;
        I_abort = 1'b0;
        check("sa_load", 128'(O_load), 0);
        check("sa_busy", 128'(O_busy), 0);
        settle();
        check("sa_nload", 128'(n_load - b_load), 0);

        // Count zero: done one cycle after start, no load
        mark();
        start_batch(0, MODE_FIXED, 1'b1, PT_FIPS);
        check("z_done_t1", 128'(O_done), 1);
        check("z_load_t1", 128'(O_load), 0);
        check("z_iter", 128'(O_iter), 0);
        settle();
        check("z_nload", 128'(n_load - b_load), 0);

        // Start re-pulsed mid-batch is ignored
        mark();
        start_batch(3, MODE_FIXED, 1'b1, PT_FIPS);
        @(negedge crypto_clk);
        I_start = 1'b1;
        I_count = 16'd1;
        @(negedge crypto_clk);
        I_start = 1'b0;
        wait_done(seen);
        check("rs_done", 128'(seen), 1);
        check("rs_iter", 128'(O_iter), 3);
        settle();
        check("rs_nload", 128'(n_load - b_load), 3);

        // Instant core: ARM times out and the result is still captured
        lat = 0;
        start_batch(1, MODE_FIXED, 1'b1, 128'h1);
        wait_done(seen);
        check("ins_done", 128'(seen), 1);
        check("ins_iter", 128'(O_iter), 1);
        check("ins_ct", O_cipherout, ~128'h1);
        lat = 5;
        settle();

        // Reset during ARM, then a normal batch
        mark();
        start_batch(3, MODE_FIXED, 1'b1, PT_FIPS);
        @(negedge crypto_clk);
        resetn = 1'b0;
        #1;
        check("ra_ctrl", 128'({O_load, O_busy, O_done, O_trigger}), 0);
        check("ra_iter", 128'(O_iter), 0);
        check("ra_text", O_textout, 0);
        check("ra_ct", O_cipherout, 0);
        repeat (2) @(negedge crypto_clk);
        resetn = 1'b1;
        settle();
        check("ra_ndone", 128'(n_done - b_done), 0);
        start_batch(2, MODE_CHAIN, 1'b1, PT_FIPS);
        wait_done(seen);
        check("ra2_done", 128'(seen), 1);
        check("ra2_iter", 128'(O_iter), 2);
        check("ra2_ct", O_cipherout, CT_CHAIN);
        settle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
